adc045_wrapper: RTL and testbench

Control and readout front-end for the external 24-bit ADC045 converter. It drives the converter's reset, START and serial clock pins, sends one configuration (WREG) frame on request, and then streams conversions. In streaming mode it shifts in 24-bit samples on `dout` and, on each DRDY pulse, presents the latched sample to the upstream datapath with a one-cycle strobe.

---
 rtl/adc045_pkg.sv | 19 +
 rtl/adc045_reader.sv | 116 +++++++++++
 rtl/adc045_wrapper.sv | 145 ++++++++++++++
 tb/tb_adc045_wrapper.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc045_pkg.sv
// adc045_pkg: shared types and constants for the ADC045 control/readout front-end.
//   adc_state_e  : wrapper FSM state (IDLE, WREG, WORK)
//   WREG_OPCODE  : WREG command opcode, OR-ed with the first register address
//   WREG_BYTES   : bytes per WREG frame (opcode, count, three config bytes)
//   SAMPLE_W     : ADC sample width
package adc045_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WREG = 2'd1,
    WORK = 2'd2
  } adc_state_e;

  localparam logic [7:0]  WREG_OPCODE = 8'h40;
  localparam int unsigned WREG_BYTES  = 5;
  localparam int unsigned WREG_BITS   = WREG_BYTES * 8;
  localparam int unsigned SAMPLE_W    = 24;

endpackage

// File: rtl/adc045_reader.sv
// adc045_reader: sclk generator, streaming sample shifter and DRDY capture.
// Optional feature: define ADC045_CS_GATE_EN to pause sclk/shift/capture while cs_i=1.
// Ports:
//   clk, rst        : system clock, async active-high reset
//   clr_n_i         : active-low ADC reset request; stops sclk and clears DRDY history
//   work_mode       : streaming mode (sclk runs, samples shifted and captured)
//   wreg_mode_i     : WREG frame in progress (sclk runs only)
//   cs_i            : active-low interface enable (used only with ADC045_CS_GATE_EN)
//   drdy_i, dout_i  : ADC data-ready (async) and serial data
//   sclk_o          : serial clock, idles low
//   sclk_rise_c/_fall_c : single-cycle strobes on the clk edge where sclk_o toggles
//   ready_sample_o  : one-cycle new-sample strobe
//   sample_o        : latest captured sample
module adc045_reader
  import adc045_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_n_i,
  input  logic                work_mode,
  input  logic                wreg_mode_i,
  input  logic                cs_i,
  input  logic                drdy_i,
  input  logic                dout_i,
  output logic                sclk_o,
  output logic                sclk_rise_c,
  output logic                sclk_fall_c,
  output logic                ready_sample_o,
  output logic [SAMPLE_W-1:0] sample_o
);

  localparam int unsigned CNT_W = $clog2(SCLK_HALF);

  logic [CNT_W-1:0]    half_cnt_q;
  logic                sclk_q;
  logic                active_c;
  logic                paused_c;
  logic                edge_c;
  logic [1:0]          drdy_sync_q;
  logic                drdy_s_c;
  logic                drdy_prev_q;
  logic                cap_c;
  logic [SAMPLE_W-1:0] shift_q;
  logic [SAMPLE_W-1:0] data_q;
  logic                ready_q;

`ifdef ADC045_CS_GATE_EN
  assign paused_c = cs_i;
`else
  logic unused_cs;
  assign unused_cs = cs_i;
  assign paused_c  = 1'b0;
`endif

  assign active_c    = (work_mode | wreg_mode_i) & clr_n_i;
  assign edge_c      = active_c & ~paused_c & (half_cnt_q == CNT_W'(SCLK_HALF - 1));
  assign sclk_rise_c = edge_c & ~sclk_q;
  assign sclk_fall_c = edge_c & sclk_q;

  // sclk generator: half-period counter; held low when idle, paused low when gated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt_q <= '0;
      sclk_q     <= 1'b0;
    end else if (!active_c) begin
      half_cnt_q <= '0;
      sclk_q     <= 1'b0;
    end else if (paused_c) begin
      sclk_q     <= 1'b0;
    end else if (edge_c) begin
      half_cnt_q <= '0;
      sclk_q     <= ~sclk_q;
    end else begin
      half_cnt_q <= half_cnt_q + CNT_W'(1);
    end
  end

  // Two-flop DRDY synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drdy_sync_q <= '0;
    else     drdy_sync_q <= {drdy_sync_q[0], drdy_i};
  end

  assign drdy_s_c = drdy_sync_q[1];
  assign cap_c    = work_mode & sclk_fall_c & drdy_s_c & ~drdy_prev_q;

  // Shift on sclk falls; a DRDY rising event latches the word instead of shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drdy_prev_q <= 1'b0;
      shift_q     <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (!clr_n_i) begin
        drdy_prev_q <= 1'b0;
      end else if (work_mode && sclk_fall_c) begin
        drdy_prev_q <= drdy_s_c;
        if (cap_c) begin
          data_q  <= shift_q;
          ready_q <= 1'b1;
        end else begin
          shift_q <= {shift_q[SAMPLE_W-2:0], dout_i};
        end
      end
    end
  end

  assign sclk_o         = sclk_q;
  assign ready_sample_o = ready_q;
  assign sample_o       = data_q;

endmodule

// File: rtl/adc045_wrapper.sv
// adc045_wrapper: ADC045 control FSM, WREG serializer and nRST pulse generator.
// Optional feature: ADC045_CS_GATE_EN (cs gating, implemented in adc045_reader).
// Ports:
//   clk, rst            : system clock, async active-high reset
//   drdy, dout, cs      : ADC data-ready, serial data, active-low interface enable
//   din, sclk           : serial data and clock to the ADC
//   nRST, start         : ADC reset (active low) and START pin
//   hard_start          : one-cycle request to enter streaming mode
//   hard_wreg           : one-cycle request to send the WREG frame
//   rst_l_adc           : active-low ADC reset request
//   ready_sample        : one-cycle new-sample strobe
//   adc045_data         : latest sample, raw two's complement
module adc045_wrapper
  import adc045_pkg::*;
#(
  parameter int unsigned SCLK_HALF     = 4,
  parameter int unsigned RST_PULSE_CYC = 16,
  parameter logic [3:0]  WREG_ADDR     = 4'h0,
  parameter logic [7:0]  CFG0          = 8'h00,
  parameter logic [7:0]  CFG1          = 8'h00,
  parameter logic [7:0]  CFG2          = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                drdy,
  input  logic                dout,
  input  logic                cs,
  output logic                din,
  output logic                sclk,
  output logic                nRST,
  output logic                start,
  input  logic                hard_start,
  input  logic                hard_wreg,
  input  logic                rst_l_adc,
  output logic                ready_sample,
  output logic [SAMPLE_W-1:0] adc045_data
);

  localparam int unsigned RST_CNT_W = $clog2(RST_PULSE_CYC + 1);
  localparam int unsigned BIT_CNT_W = $clog2(WREG_BITS);
  localparam logic [WREG_BITS-1:0] WREG_FRAME =
    {WREG_OPCODE | {4'h0, WREG_ADDR}, 8'h02, CFG0, CFG1, CFG2};

  adc_state_e             state_q;
  logic                   start_q;
  logic                   din_q;
  logic                   done_q;
  logic [WREG_BITS-1:0]   frame_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic                   nrst_q;
  logic [RST_CNT_W-1:0]   rst_cnt_q;
  logic                   work_mode;
  logic                   wreg_mode;
  logic                   sclk_rise_c;
  logic                   sclk_fall_c;

  assign work_mode = (state_q == WORK);
  assign wreg_mode = (state_q == WREG);

  // nRST: low while rst_l_adc is low, released RST_PULSE_CYC cycles after it returns high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nrst_q    <= 1'b0;
      rst_cnt_q <= RST_CNT_W'(RST_PULSE_CYC);
    end else if (!rst_l_adc) begin
      nrst_q    <= 1'b0;
      rst_cnt_q <= '0;
    end else if (!nrst_q) begin
      if (rst_cnt_q == RST_CNT_W'(RST_PULSE_CYC)) nrst_q <= 1'b1;
      else                                         rst_cnt_q <= rst_cnt_q + RST_CNT_W'(1);
    end
  end

  // Control FSM; din updates on sclk rises, frame ends after the 40th fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      din_q     <= 1'b0;
      done_q    <= 1'b0;
      frame_q   <= '0;
      bit_cnt_q <= '0;
    end else if (!rst_l_adc) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      din_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hard_wreg) begin
            state_q   <= WREG;
            frame_q   <= WREG_FRAME;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
          end else if (hard_start) begin
            state_q <= WORK;
            start_q <= 1'b1;
          end
        end
        WREG: begin
          if (done_q) begin
            state_q <= IDLE;
            din_q   <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            if (sclk_rise_c) begin
              din_q   <= frame_q[WREG_BITS-1];
              frame_q <= {frame_q[WREG_BITS-2:0], 1'b0};
            end
            if (sclk_fall_c) begin
              if (bit_cnt_q == BIT_CNT_W'(WREG_BITS - 1)) done_q    <= 1'b1;
              else                                          bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
        WORK:    start_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  adc045_reader #(
    .SCLK_HALF(SCLK_HALF)
  ) adc_rd (
    .clk           (clk),
    .rst           (rst),
    .clr_n_i       (rst_l_adc),
    .work_mode     (work_mode),
    .wreg_mode_i   (wreg_mode),
    .cs_i          (cs),
    .drdy_i        (drdy),
    .dout_i        (dout),
    .sclk_o        (sclk),
    .sclk_rise_c   (sclk_rise_c),
    .sclk_fall_c   (sclk_fall_c),
    .ready_sample_o(ready_sample),
    .sample_o      (adc045_data)
  );

  assign din   = din_q;
  assign nRST  = nrst_q;
  assign start = start_q;

endmodule

// File: tb/tb_adc045_wrapper.sv
// tb_adc045_wrapper: directed bench for adc045_wrapper with a simple ADC serial model.
module tb_adc045_wrapper;

  logic        clk = 1'b0;
  logic        rst;
  logic        drdy;
  logic        dout;
  logic        cs;
  logic        din;
  logic        sclk;
  logic        nRST;
  logic        start;
  logic        hard_start;
  logic        hard_wreg;
  logic        rst_l_adc;
  logic        ready_sample;
  logic [23:0] adc045_data;

  int          checks   = 0;
  int          failures = 0;
  logic [23:0] samples[$];

  always #5 clk = ~clk;

  adc045_wrapper #(
    .SCLK_HALF    (4),
    .RST_PULSE_CYC(16),
    .WREG_ADDR    (4'h0),
    .CFG0         (8'h11),
    .CFG1         (8'h22),
    .CFG2         (8'h33)
  ) uut (
    .clk         (clk),
    .rst         (rst),
    .drdy        (drdy),
    .dout        (dout),
    .cs          (cs),
    .din         (din),
    .sclk        (sclk),
    .nRST        (nRST),
    .start       (start),
    .hard_start  (hard_start),
    .hard_wreg   (hard_wreg),
    .rst_l_adc   (rst_l_adc),
    .ready_sample(ready_sample),
    .adc045_data (adc045_data)
  );

  // Record every sample strobe
  always @(negedge clk) begin
    if (ready_sample) samples.push_back(adc045_data);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the next sclk rising edge (returns 1 time unit after it)
  task automatic wait_rise();
    logic prev;
    bit   ok;
    prev = sclk;
    ok   = 1'b0;
    for (int n = 0; n < 64; n++) begin
      tick();
      if (sclk && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = sclk;
    end
    check("sclk_rise_wait", 64'(ok), 64'd1);
  endtask

  // ADC model: 24 bits MSB first on sclk rises, then a one-period DRDY pulse
  task automatic send_sample(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) begin
      wait_rise();
      dout = v[i];
    end
    wait_rise();
    drdy = 1'b1;
    wait_rise();
    drdy = 1'b0;
    dout = 1'b0;
  endtask

  task automatic measure_nrst_low(output int n);
    n = 0;
    while (nRST === 1'b0 && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          highs;
    logic        prev;
    logic [39:0] bits;

    rst = 1'b0; drdy = 1'b0; dout = 1'b0; cs = 1'b0;
    hard_start = 1'b0; hard_wreg = 1'b0; rst_l_adc = 1'b1;
    #2 rst = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_nRST",   64'(nRST),         64'd0);
    check("rst_sclk",   64'(sclk),         64'd0);
    check("rst_start",  64'(start),        64'd0);
    check("rst_din",    64'(din),          64'd0);
    check("rst_ready",  64'(ready_sample), 64'd0);
    check("rst_data",   64'(adc045_data),  64'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    check("post_rst_nRST", 64'(nRST), 64'd1);

    // One-cycle ADC reset request
    tick(); rst_l_adc = 1'b0;
    tick(); rst_l_adc = 1'b1;
    measure_nrst_low(n);
    check("nrst_low_cycles", 64'(n), 64'd17);
    check("nrst_work_mode",  64'(uut.adc_rd.work_mode), 64'd0);
    check("nrst_released",   64'(nRST), 64'd1);

    // WREG frame; hard_start coinciding and mid-frame must be ignored
    tick(); hard_wreg = 1'b1; hard_start = 1'b1;
    tick(); hard_wreg = 1'b0; hard_start = 1'b0;
    bits = '0;
    n    = 0;
    prev = sclk;
    for (int i = 0; i < 400 && n < 40; i++) begin
      tick();
      if (i == 50) hard_start = 1'b1;
      if (i == 51) hard_start = 1'b0;
      if (prev && !sclk) begin
        bits = {bits[38:0], din};
        n++;
      end
      prev = sclk;
    end
    check("wreg_bit_count", 64'(n),    64'd40);
    check("wreg_frame",     64'(bits), 64'h40_02_11_22_33);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (sclk) highs++;
    end
    check("wreg_sclk_idle",  64'(highs), 64'd0);
    check("wreg_din_idle",   64'(din),   64'd0);
    check("wreg_start_low",  64'(start), 64'd0);
    check("wreg_state_idle", 64'(uut.state_q), 64'd0);

    // Enter streaming mode
    tick(); hard_start = 1'b1;
    tick(); hard_start = 1'b0;
    check("start_high",     64'(start), 64'd1);
    check("work_mode_high", 64'(uut.adc_rd.work_mode), 64'd1);

    send_sample(24'h7FFFFF);
    tick();
    check("s0_strobes", 64'(samples.size()), 64'd1);
    if (samples.size() >= 1) check("s0_value", 64'(samples[0]), 64'h7FFFFF);
    check("s0_data_hold", 64'(adc045_data), 64'h7FFFFF);

    // hard_wreg must be ignored in WORK
    hard_wreg = 1'b1;
    tick(); hard_wreg = 1'b0;
    check("work_wreg_ignored", 64'(uut.adc_rd.work_mode), 64'd1);
    check("work_din_low",      64'(din), 64'd0);

    send_sample(24'h800001);
    send_sample(24'h000000);
    send_sample(24'hA5A5A5);
    tick();
    check("multi_strobes", 64'(samples.size()), 64'd4);
    if (samples.size() >= 4) begin
      check("s1_value", 64'(samples[1]), 64'h800001);
      check("s2_value", 64'(samples[2]), 64'h000000);
      check("s3_value", 64'(samples[3]), 64'hA5A5A5);
    end
    check("multi_start_high", 64'(start), 64'd1);

    // ADC reset mid-sample, with DRDY raised just before the capturing fall
    for (int i = 0; i < 10; i++) begin
      wait_rise();
      dout = i[0];
    end
    wait_rise();
    drdy = 1'b1;
    tick(); rst_l_adc = 1'b0;
    tick(); rst_l_adc = 1'b1;
    check("abort_start_low", 64'(start), 64'd0);
    check("abort_sclk_low",  64'(sclk),  64'd0);
    measure_nrst_low(n);
    check("abort_nrst_low_cycles", 64'(n), 64'd17);
    drdy = 1'b0;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sclk) highs++;
    end
    check("abort_sclk_idle", 64'(highs), 64'd0);
    check("abort_strobes",   64'(samples.size()), 64'd4);
    check("abort_data_kept", 64'(adc045_data), 64'hA5A5A5);
    check("abort_work_mode", 64'(uut.adc_rd.work_mode), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
